// File: rtl/y86_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the SEQ sequencer and its surroundings.
// The slave side is the sequencer. The master side is the fetch/execute/memory blocks, or a bench.
// The bundle holds no state and carries no flow control of its own.
interface y86_seq_ctrl_if;
  logic        start_i;
  logic        stop_i;
  logic [3:0]  icode_i;
  logic        instr_valid_i;
  logic        cnd_i;
  logic [63:0] valC_i;
  logic [63:0] valP_i;
  logic [63:0] valM_i;
  logic        mem_ready_i;
  logic        fetch_en_o;
  logic        decode_en_o;
  logic        exec_en_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        wbE_en_o;
  logic        wbM_en_o;
  logic [63:0] pc_o;
  logic [1:0]  stat_o;
  logic        busy_o;
  logic        instr_done_o;

  modport slave (
    input  start_i, stop_i, icode_i, instr_valid_i, cnd_i,
    input  valC_i, valP_i, valM_i, mem_ready_i,
    output fetch_en_o, decode_en_o, exec_en_o, mem_req_o, mem_we_o,
    output wbE_en_o, wbM_en_o, pc_o, stat_o, busy_o, instr_done_o
  );

  modport master (
    output start_i, stop_i, icode_i, instr_valid_i, cnd_i,
    output valC_i, valP_i, valM_i, mem_ready_i,
    input  fetch_en_o, decode_en_o, exec_en_o, mem_req_o, mem_we_o,
    input  wbE_en_o, wbM_en_o, pc_o, stat_o, busy_o, instr_done_o
  );
endinterface

// File: rtl/y86_seq_ctrl.sv
// Y86-64 SEQ multi-cycle sequencer: one-hot stage enables, write-back enables, next PC and status.
// Latency: 5 cycles per instruction, plus N MEMORY cycles for instructions that access memory.
// Backpressure: MEMORY waits on mem_ready_i for up to MEM_TIMEOUT cycles, then faults with ADR.
module y86_seq_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  y86_seq_ctrl_if.slave  bus
);

  localparam int unsigned   CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] I_HALT   = 4'h1;
  localparam logic [3:0] I_RRMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_ALU    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALTED, S_ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [1:0]     stat_q, stat_d;
  logic [3:0]     icode_q, icode_d;
  logic           cnd_q, cnd_d;
  logic [CW-1:0]  wait_q, wait_d;

  // State, PC, status and per-instruction latches; reset is asynchronous.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, latch updates and PC selection; the wait counter is zero outside MEMORY.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        icode_d = bus.icode_i;
        if (!bus.instr_valid_i) begin
          state_d = S_ERROR;
          stat_d  = STAT_INS;
        end else if (bus.icode_i == I_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        cnd_d   = bus.cnd_i;
        state_d = (icode_q inside {I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP}) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready_i) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        case (icode_q)
          I_CALL:  pc_d = bus.valC_i;
          I_RET:   pc_d = bus.valM_i;
          I_JXX:   pc_d = cnd_q ? bus.valC_i : bus.valP_i;
          default: pc_d = bus.valP_i;
        endcase
        state_d = bus.stop_i ? S_IDLE : S_FETCH;
      end
      default: state_d = state_q;  // HALTED and ERROR hold until reset
    endcase
  end

  // Moore outputs decoded only from registered state, icode and condition.
  assign bus.fetch_en_o   = (state_q == S_FETCH);
  assign bus.decode_en_o  = (state_q == S_DECODE);
  assign bus.exec_en_o    = (state_q == S_EXEC);
  assign bus.mem_req_o    = (state_q == S_MEM);
  assign bus.mem_we_o     = (state_q == S_MEM) && (icode_q inside {I_RMMOV, I_CALL, I_PUSH});
  assign bus.wbE_en_o     = (state_q == S_WB) &&
                            ((icode_q inside {I_IRMOV, I_ALU, I_CALL, I_RET, I_PUSH, I_POP}) ||
                             ((icode_q == I_RRMOV) && cnd_q));
  assign bus.wbM_en_o     = (state_q == S_WB) && (icode_q inside {I_MRMOV, I_POP});
  assign bus.instr_done_o = (state_q == S_PCUPD);
  assign bus.busy_o       = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD});
  assign bus.pc_o         = pc_q;
  assign bus.stat_o       = stat_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: directed scenarios followed by random instructions.
// Expected stage traces, write counts, PC and status come from a rule-level model.
// Each instruction is launched from IDLE with stop_i high so that it ends back in IDLE.
module tb_y86_seq_ctrl;
  localparam int TMO = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  y86_seq_ctrl_if bus ();

  y86_seq_ctrl #(.RESET_PC(64'h0), .MEM_TIMEOUT(TMO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc = 64'h0;
  logic [1:0]  exp_stat = 2'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_pc   = 64'h0;
    exp_stat = 2'd0;
  endtask

  function automatic bit is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic bit is_write(input logic [3:0] ic);
    return ic inside {4'h4, 4'h8, 4'hA};
  endfunction

  // Runs one instruction from IDLE and compares its observed behaviour with the model.
  task automatic run_instr(input string tag, input logic [3:0] ic, input bit valid, input bit cnd,
                           input int ready_at, input logic [63:0] vc, input logic [63:0] vp,
                           input logic [63:0] vm, output bit terminal);
    byte got[$];
    byte exp[$];
    int  n = 0, memn = 0, wbe = 0, wbm = 0, we = 0, done = 0, diffs = 0;
    int  exp_wbe = 0, exp_wbm = 0, exp_we = 0, exp_done = 0;
    byte s;
    // Model: expected stage trace and side effects.
    terminal = 1'b0;
    exp.push_back("F");
    if (!valid) begin
      exp_stat = 2'd3;
      terminal = 1'b1;
    end else if (ic == 4'h1) begin
      exp_stat = 2'd1;
      terminal = 1'b1;
    end else begin
      exp.push_back("D");
      exp.push_back("E");
      if (is_mem(ic)) begin
        int nm;
        nm = (ready_at >= 1 && ready_at <= TMO) ? ready_at : TMO;
        for (int i = 0; i < nm; i++) exp.push_back("M");
        if (is_write(ic)) exp_we = nm;
        if (nm != ready_at) begin
          exp_stat = 2'd2;
          terminal = 1'b1;
        end
      end
      if (!terminal) begin
        exp.push_back("W");
        exp.push_back("P");
        exp_done = 1;
        if ((ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && cnd)) exp_wbe = 1;
        if (ic inside {4'h5, 4'hB}) exp_wbm = 1;
        if (ic == 4'h8)      exp_pc = vc;
        else if (ic == 4'h9) exp_pc = vm;
        else if (ic == 4'h7) exp_pc = cnd ? vc : vp;
        else                 exp_pc = vp;
      end
    end
    // Stimulus and observation.
    bus.icode_i = ic;  bus.instr_valid_i = valid;  bus.cnd_i = cnd;
    bus.valC_i = vc;   bus.valP_i = vp;            bus.valM_i = vm;
    bus.mem_ready_i = 1'b0;  bus.stop_i = 1'b1;    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      s = bus.fetch_en_o ? "F" : bus.decode_en_o ? "D" : bus.exec_en_o ? "E" :
          bus.mem_req_o ? "M" : bus.instr_done_o ? "P" : "W";
      got.push_back(s);
      n++;
      if (bus.mem_req_o) begin
        memn++;
        if (bus.mem_we_o) we++;
        bus.mem_ready_i = (memn == ready_at);
      end else begin
        bus.mem_ready_i = 1'b0;
      end
      wbe  += int'(bus.wbE_en_o);
      wbm  += int'(bus.wbM_en_o);
      done += int'(bus.instr_done_o);
      tick();
    end
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] != exp[i]) diffs++;
    check({tag, " trace_len"},   64'(got.size()), 64'(exp.size()));
    check({tag, " trace_diffs"}, 64'(diffs),      64'(0));
    check({tag, " wbE_cnt"},     64'(wbe),        64'(exp_wbe));
    check({tag, " wbM_cnt"},     64'(wbm),        64'(exp_wbm));
    check({tag, " we_cnt"},      64'(we),         64'(exp_we));
    check({tag, " done_cnt"},    64'(done),       64'(exp_done));
    check({tag, " pc"},          bus.pc_o,        exp_pc);
    check({tag, " stat"},        64'(bus.stat_o), 64'(exp_stat));
  endtask

  // Terminal states must ignore start_i and keep pc/status.
  task automatic check_terminal(input string tag);
    bus.start_i = 1'b1;
    repeat (3) tick();
    bus.start_i = 1'b0;
    tick();
    check({tag, " term_busy"},  64'(bus.busy_o),     64'(0));
    check({tag, " term_fetch"}, 64'(bus.fetch_en_o), 64'(0));
    check({tag, " term_stat"},  64'(bus.stat_o),     64'(exp_stat));
    check({tag, " term_pc"},    bus.pc_o,            exp_pc);
  endtask

  initial begin
    bit term;
    bus.start_i = 1'b0;  bus.stop_i = 1'b0;  bus.icode_i = 4'h0;  bus.instr_valid_i = 1'b1;
    bus.cnd_i = 1'b0;    bus.valC_i = '0;    bus.valP_i = '0;     bus.valM_i = '0;
    bus.mem_ready_i = 1'b0;

    // Reset state, observed while reset is held.
    #12;
    check("rst pc",   bus.pc_o, 64'h0);
    check("rst stat", 64'(bus.stat_o), 64'(0));
    check("rst outs", 64'({bus.fetch_en_o, bus.decode_en_o, bus.exec_en_o, bus.mem_req_o,
                           bus.mem_we_o, bus.wbE_en_o, bus.wbM_en_o, bus.busy_o,
                           bus.instr_done_o}), 64'(0));
    rst_i = 1'b0;
    tick();

    // Directed scenarios.
    run_instr("alu",    4'h6, 1, 0, 0, 64'h0,   64'h2, 64'h0,  term);
    run_instr("mrmov",  4'h5, 1, 0, 3, 64'h0,   64'hA, 64'h0,  term);
    run_instr("jxx_nt", 4'h7, 1, 0, 0, 64'h100, 64'h9, 64'h40, term);
    run_instr("jxx_t",  4'h7, 1, 1, 0, 64'h100, 64'h9, 64'h40, term);
    run_instr("ret",    4'h9, 1, 0, 1, 64'h100, 64'h9, 64'h40, term);
    run_instr("call",   4'h8, 1, 0, 2, 64'h100, 64'h9, 64'h40, term);

    // Asynchronous reset in the middle of a MEMORY wait.
    bus.icode_i = 4'hA;  bus.instr_valid_i = 1'b1;  bus.mem_ready_i = 1'b0;  bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    check("arst pre_mem_req", 64'(bus.mem_req_o), 64'(1));
    #2;
    rst_i = 1'b1;
    #1;
    check("arst mem_req", 64'(bus.mem_req_o), 64'(0));
    check("arst busy",    64'(bus.busy_o),    64'(0));
    check("arst pc",      bus.pc_o,           64'h0);
    check("arst stat",    64'(bus.stat_o),    64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_pc = 64'h0;
    exp_stat = 2'd0;
    bus.icode_i = 4'h0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("arst restart_fetch", 64'(bus.fetch_en_o), 64'(1));
    do_reset();

    // Faults.
    run_instr("halt", 4'h1, 1, 0, 0, 64'h0, 64'h7, 64'h0, term);
    check_terminal("halt");
    do_reset();
    run_instr("pre_ins", 4'h3, 1, 0, 0, 64'h0, 64'h30, 64'h0, term);
    run_instr("ins",     4'h6, 0, 0, 0, 64'h0, 64'h99, 64'h0, term);
    check_terminal("ins");
    do_reset();
    run_instr("pre_tmo", 4'h0, 1, 0, 0, 64'h0, 64'h50, 64'h0, term);
    run_instr("tmo",     4'hA, 1, 0, 0, 64'h0, 64'h60, 64'h0, term);
    check_terminal("tmo");
    do_reset();

    // Random instructions.
    for (int k = 0; k < 30; k++) begin
      logic [3:0] ic;
      bit         vld, cnd;
      int         rdy;
      ic  = 4'($urandom_range(0, 11));
      vld = ($urandom_range(0, 9) != 0);
      cnd = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_instr($sformatf("rnd%0d", k), ic, vld, cnd, rdy,
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, term);
      if (term) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
